// File: rtl/core_run_ctrl_pkg.sv
// Shared types and helpers for the core reset/run sequencer.
package core_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_STRETCH,
        ST_RELEASE,
        ST_RUN,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_REQ   = 2'd1,
        CAUSE_LIMIT = 2'd2,
        CAUSE_WDT   = 2'd3
    } halt_cause_e;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/core_run_ctrl_rst_sync.sv
// Two-flop reset synchroniser: assertion is asynchronous, deassertion is
// aligned to clk so downstream logic never sees a release near an edge.
module core_run_ctrl_rst_sync (
    input  logic clk,
    input  logic reset,
    output logic rst_sync_n
);

    logic meta_q;

    // Shift a one through two flops after reset goes high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q     <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old
            // value on the same edge; blocking here would collapse the chain.
            meta_q     <= 1'b1;
            rst_sync_n <= meta_q;
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Reset/run sequencer for the RISC-V datapath.
// After the synchronised reset release, all channel resets are stretched,
// then released one by one (channel 0 first), then the core runs until a
// halt request, the cycle limit, or (optionally) the watchdog stops it.
// Optional watchdog: define CORE_RUN_CTRL_WATCHDOG_EN.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int NUM_CH         = 3,
    parameter int STRETCH_CYCLES = 4,
    parameter int RELEASE_GAP    = 2,
    parameter int MAX_CYCLES     = 100,
    parameter int CNT_W          = 16,
    parameter int WDT_CYCLES     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              soft_rst_req,
    input  logic              halt_req,
    input  logic              heartbeat,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              running,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int                SEQ_W        = cnt_width(imax(STRETCH_CYCLES, RELEASE_GAP));
    localparam logic [SEQ_W-1:0]  STRETCH_LAST = SEQ_W'(STRETCH_CYCLES - 1);
    localparam logic [SEQ_W-1:0]  GAP_LAST     = SEQ_W'(RELEASE_GAP - 1);
    localparam bit                LIMIT_EN     = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0]  LIMIT_VAL    = CNT_W'(MAX_CYCLES);
    localparam logic [NUM_CH-1:0] CH_FIRST     = NUM_CH'(1);

    logic        rst_sync_n;

    state_e      state_q, state_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [NUM_CH-1:0] ch_q, ch_d;
    logic        running_q, running_d;
    logic        halted_q, halted_d;
    halt_cause_e cause_q, cause_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  count_inc;
    logic        wdt_hit;

    core_run_ctrl_rst_sync u_rst_sync (
        .clk        (clk),
        .reset      (reset),
        .rst_sync_n (rst_sync_n)
    );

`ifdef CORE_RUN_CTRL_WATCHDOG_EN
    localparam int               WDT_W    = cnt_width(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES);

    logic [WDT_W-1:0] wdt_q, wdt_d;

    // Watchdog: held clear outside the run phase, cleared by each heartbeat.
    always_comb begin
        wdt_d   = '0;
        wdt_hit = 1'b0;
        if (state_q == ST_RUN && !heartbeat) begin
            wdt_d   = wdt_q + WDT_W'(1);
            wdt_hit = (wdt_d == WDT_LAST);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic unused_heartbeat;

    // No watchdog in this build: heartbeat is not observed.
    always_comb begin
        unused_heartbeat = heartbeat;
        wdt_hit          = 1'b0;
    end
`endif

    // Saturating run-cycle increment.
    always_comb begin
        count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first; any path
        // that skipped an assignment would otherwise infer a latch.
        state_d   = state_q;
        seq_d     = seq_q;
        ch_d      = ch_q;
        running_d = running_q;
        halted_d  = halted_q;
        cause_d   = cause_q;
        count_d   = count_q;

        if (soft_rst_req && state_q != ST_RESET) begin
            // Restart replays the whole stretch/release sequence.
            state_d   = ST_STRETCH;
            seq_d     = '0;
            ch_d      = '0;
            running_d = 1'b0;
            halted_d  = 1'b0;
            cause_d   = CAUSE_NONE;
            count_d   = '0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (rst_sync_n) begin
                        state_d = ST_STRETCH;
                        seq_d   = '0;
                    end
                end

                ST_STRETCH: begin
                    if (seq_q == STRETCH_LAST) begin
                        state_d = ST_RELEASE;
                        seq_d   = '0;
                        ch_d    = CH_FIRST;
                    end else begin
                        seq_d = seq_q + SEQ_W'(1);
                    end
                end

                ST_RELEASE: begin
                    // Channels release as a thermometer code from bit 0 up.
                    if (&ch_q) begin
                        state_d   = ST_RUN;
                        running_d = 1'b1;
                        count_d   = '0;
                    end else if (seq_q == GAP_LAST) begin
                        ch_d  = (ch_q << 1) | CH_FIRST;
                        seq_d = '0;
                    end else begin
                        seq_d = seq_q + SEQ_W'(1);
                    end
                end

                ST_RUN: begin
                    // Halt priority: request, then limit, then watchdog.
                    if (halt_req) begin
                        state_d   = ST_HALT;
                        running_d = 1'b0;
                        halted_d  = 1'b1;
                        cause_d   = CAUSE_REQ;
                    end else if (LIMIT_EN && count_inc == LIMIT_VAL) begin
                        state_d   = ST_HALT;
                        running_d = 1'b0;
                        halted_d  = 1'b1;
                        cause_d   = CAUSE_LIMIT;
                        count_d   = count_inc;
                    end else if (wdt_hit) begin
                        state_d   = ST_HALT;
                        running_d = 1'b0;
                        halted_d  = 1'b1;
                        cause_d   = CAUSE_WDT;
                        count_d   = count_inc;
                    end else begin
                        count_d = count_inc;
                    end
                end

                ST_HALT: begin
                    // Everything frozen; channels stay released for debug.
                end

                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    // State and registered outputs; raw reset clears them asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RESET;
            seq_q     <= '0;
            ch_q      <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            cause_q   <= CAUSE_NONE;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            ch_q      <= ch_d;
            running_q <= running_d;
            halted_q  <= halted_d;
            cause_q   <= cause_d;
            count_q   <= count_d;
        end
    end

    // Drive ports straight from registers.
    always_comb begin
        ch_rst_n    = ch_q;
        running     = running_q;
        halted      = halted_q;
        halt_cause  = cause_q;
        cycle_count = count_q;
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl. Edge numbers count rising clock edges
// after reset is released. Snapshots pack {ch_rst_n, running, halted,
// halt_cause, cycle_count} and are printed in hex.
module tb_core_run_ctrl;

`ifdef CORE_RUN_CTRL_WATCHDOG_EN
    localparam int TB_MAX = 0;
`else
    localparam int TB_MAX = 100;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        soft_rst_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        heartbeat = 1'b0;
    logic [2:0]  ch_rst_n;
    logic        running;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [15:0] cycle_count;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int base;

    logic [22:0] exp_s;
    logic [3:0]  exp_st;
    wire  [22:0] obs    = {ch_rst_n, running, halted, halt_cause, cycle_count};
    wire  [3:0]  obs_st = {running, halted, halt_cause};

    core_run_ctrl #(.MAX_CYCLES(TB_MAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .soft_rst_req (soft_rst_req),
        .halt_req     (halt_req),
        .heartbeat    (heartbeat),
        .ch_rst_n     (ch_rst_n),
        .running      (running),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic goto_edge(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    task automatic step(input int n);
        goto_edge(edge_n + n);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset  = 1'b1;
        edge_n = 0;
    endtask

    task automatic pulse_soft();
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        exp_s = '0;
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL reset_state got %h exp %h", obs, exp_s); end
    endtask

    task automatic test_power_up();
        release_reset();
        goto_edge(2);
        exp_s = {3'b000, 1'b0, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL pu_e2 got %h exp %h", obs, exp_s); end
        goto_edge(6);
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL pu_e6 got %h exp %h", obs, exp_s); end
        goto_edge(7);
        exp_s = {3'b001, 1'b0, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL pu_e7 got %h exp %h", obs, exp_s); end
        goto_edge(8);
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL pu_e8 got %h exp %h", obs, exp_s); end
        goto_edge(9);
        exp_s = {3'b011, 1'b0, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL pu_e9 got %h exp %h", obs, exp_s); end
        goto_edge(11);
        exp_s = {3'b111, 1'b0, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL pu_e11 got %h exp %h", obs, exp_s); end
        goto_edge(12);
        exp_s = {3'b111, 1'b1, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL pu_e12 got %h exp %h", obs, exp_s); end
        goto_edge(13);
        exp_s = {3'b111, 1'b1, 1'b0, 2'd0, 16'd1};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL pu_e13 got %h exp %h", obs, exp_s); end
    endtask

    task automatic test_limit();
        goto_edge(111);
        exp_s = {3'b111, 1'b1, 1'b0, 2'd0, 16'd99};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL limit_e111 got %h exp %h", obs, exp_s); end
        goto_edge(112);
        exp_s = {3'b111, 1'b0, 1'b1, 2'd2, 16'd100};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL limit_e112 got %h exp %h", obs, exp_s); end
        halt_req = 1'b1;
        step(20);
        halt_req = 1'b0;
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL limit_hold got %h exp %h", obs, exp_s); end
    endtask

`ifdef CORE_RUN_CTRL_WATCHDOG_EN
    task automatic test_watchdog();
        base = edge_n;
        for (int k = 0; k < 5; k++) begin
            step(9);
            heartbeat = 1'b1;
            step(1);
            heartbeat = 1'b0;
            exp_st = {1'b1, 1'b0, 2'd0};
            checks++;
            if (obs_st !== exp_st) begin errors++; $display("FAIL wdt_hb%0d got %h exp %h", k, obs_st, exp_st); end
        end
        step(15);
        exp_st = {1'b1, 1'b0, 2'd0};
        checks++;
        if (obs_st !== exp_st) begin errors++; $display("FAIL wdt_e15 got %h exp %h", obs_st, exp_st); end
        step(1);
        exp_st = {1'b0, 1'b1, 2'd3};
        checks++;
        if (obs_st !== exp_st) begin errors++; $display("FAIL wdt_e16 got %h exp %h", obs_st, exp_st); end
    endtask
`endif

    task automatic test_soft_restart();
        pulse_soft();
        base = edge_n;
        exp_s = {3'b000, 1'b0, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL soft_s0 got %h exp %h", obs, exp_s); end
        goto_edge(base + 3);
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL soft_s3 got %h exp %h", obs, exp_s); end
        goto_edge(base + 4);
        exp_s = {3'b001, 1'b0, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL soft_s4 got %h exp %h", obs, exp_s); end
        goto_edge(base + 6);
        exp_s = {3'b011, 1'b0, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL soft_s6 got %h exp %h", obs, exp_s); end
        goto_edge(base + 8);
        exp_s = {3'b111, 1'b0, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL soft_s8 got %h exp %h", obs, exp_s); end
        goto_edge(base + 9);
        exp_s = {3'b111, 1'b1, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL soft_s9 got %h exp %h", obs, exp_s); end
    endtask

    task automatic test_halt_req();
        base = edge_n;
        goto_edge(base + 40);
        exp_s = {3'b111, 1'b1, 1'b0, 2'd0, 16'd40};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL hreq_c40 got %h exp %h", obs, exp_s); end
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        exp_s = {3'b111, 1'b0, 1'b1, 2'd1, 16'd40};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL hreq_halt got %h exp %h", obs, exp_s); end
        halt_req = 1'b1;
        step(5);
        halt_req = 1'b0;
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL hreq_frozen got %h exp %h", obs, exp_s); end
    endtask

    task automatic test_req_vs_limit();
        pulse_soft();
        step(9);
        base = edge_n;
        goto_edge(base + 99);
        exp_s = {3'b111, 1'b1, 1'b0, 2'd0, 16'd99};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL prio_c99 got %h exp %h", obs, exp_s); end
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        exp_st = {1'b0, 1'b1, 2'd1};
        checks++;
        if (obs_st !== exp_st) begin errors++; $display("FAIL prio_cause got %h exp %h", obs_st, exp_st); end
    endtask

    task automatic test_soft_in_stretch_and_reset();
        pulse_soft();
        step(2);
        pulse_soft();
        base = edge_n;
        step(1);
        exp_s = {3'b000, 1'b0, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL restretch_s1 got %h exp %h", obs, exp_s); end
        goto_edge(base + 3);
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL restretch_s3 got %h exp %h", obs, exp_s); end
        goto_edge(base + 4);
        exp_s = {3'b001, 1'b0, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL restretch_s4 got %h exp %h", obs, exp_s); end
        goto_edge(base + 7);
        exp_s = {3'b011, 1'b0, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL midrel_pre got %h exp %h", obs, exp_s); end
        #2;
        reset = 1'b0;
        #1;
        exp_s = '0;
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL midrel_async got %h exp %h", obs, exp_s); end
        release_reset();
        goto_edge(6);
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL rerun_e6 got %h exp %h", obs, exp_s); end
        goto_edge(7);
        exp_s = {3'b001, 1'b0, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL rerun_e7 got %h exp %h", obs, exp_s); end
        goto_edge(12);
        exp_s = {3'b111, 1'b1, 1'b0, 2'd0, 16'd0};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL rerun_e12 got %h exp %h", obs, exp_s); end
    endtask

    task automatic test_soft_in_run();
        step(5);
        exp_s = {3'b111, 1'b1, 1'b0, 2'd0, 16'd5};
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL softrun_pre got %h exp %h", obs, exp_s); end
        pulse_soft();
        exp_s = '0;
        checks++;
        if (obs !== exp_s) begin errors++; $display("FAIL softrun_clr got %h exp %h", obs, exp_s); end
    endtask

    initial begin
        test_reset();
        test_power_up();
`ifdef CORE_RUN_CTRL_WATCHDOG_EN
        test_watchdog();
`else
        test_limit();
`endif
        test_soft_restart();
        test_halt_req();
        test_req_vs_limit();
        test_soft_in_stretch_and_reset();
        test_soft_in_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
